// File: rtl/pwm_multi_ch.sv
`timescale 1ns/1ps
// pwm_multi_ch
//   Multi-channel PWM generator. All channels share one free-running period
//   counter. A new period/duty set is offered over a valid/ready handshake.
//   It is held in a shadow register and committed only at a period boundary,
//   or on the next clock while stopped, so the outputs never glitch.
//
// Optional build macro: PWM_CENTER_ALIGN_EN
//   When defined, the mode_i port and centre-aligned (up/down) counting are
//   added. When undefined, only edge mode is built.
//
// Ports
//   clk_i         system clock
//   reset_ni      asynchronous active-low reset
//   enable_ni     active-low run enable (1 = stopped, counter held at 0)
//   period_i      period P offered with the set (edge cycle = P+1 clocks)
//   duty_i        packed duties, channel k at [k*CNT_W +: CNT_W]
//   mode_i        (PWM_CENTER_ALIGN_EN only) 1 = centre-aligned
//   cfg_valid_i   new set offered
//   cfg_ready_o   shadow register free (registered, equals !pending)
//   pwm_o         registered PWM outputs
//   period_end_o  one-clock pulse for the last cycle of each period
module pwm_multi_ch #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CNT_W  = 12
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    enable_ni,
  input  logic [CNT_W-1:0]        period_i,
  input  logic [NUM_CH*CNT_W-1:0] duty_i,
  input  logic                    cfg_valid_i,
`ifdef PWM_CENTER_ALIGN_EN
  input  logic                    mode_i,
`endif
  output logic                    cfg_ready_o,
  output logic [NUM_CH-1:0]       pwm_o,
  output logic                    period_end_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_next;
  logic [CNT_W-1:0]        period_act;
  logic [CNT_W-1:0]        period_shd;
  logic [NUM_CH*CNT_W-1:0] duty_act;
  logic [NUM_CH*CNT_W-1:0] duty_shd;
  logic                    pending;
  logic                    running;
  logic                    boundary;
  logic                    handshake;
  logic                    commit;
  logic [NUM_CH-1:0]       pwm_next;

`ifdef PWM_CENTER_ALIGN_EN
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
  dir_e dir;
  dir_e dir_next;
  logic mode_act;
  logic mode_shd;
`endif

  assign running   = !enable_ni;
  // cfg_ready_o mirrors !pending, so a handshake can never coincide with a
  // commit; the two branches below are mutually exclusive.
  assign handshake = cfg_valid_i && cfg_ready_o;
  assign commit    = pending && (!running || boundary);

  // Next count and boundary detection (boundary = next count is 0).
`ifdef PWM_CENTER_ALIGN_EN
  always_comb begin
    boundary = 1'b0;
    cnt_next = cnt + ONE;
    dir_next = dir;
    if (!mode_act || period_act == '0) begin
      dir_next = DIR_UP;
      if (cnt == period_act) begin
        boundary = 1'b1;
        cnt_next = '0;
      end
    end else if (dir == DIR_UP) begin
      if (cnt == period_act) begin
        // With P==1 the top is also the last cycle before 0.
        if (period_act == ONE) begin
          boundary = 1'b1;
          cnt_next = '0;
        end else begin
          dir_next = DIR_DOWN;
          cnt_next = cnt - ONE;
        end
      end
    end else begin
      if (cnt <= ONE) begin
        boundary = 1'b1;
        cnt_next = '0;
        dir_next = DIR_UP;
      end else begin
        cnt_next = cnt - ONE;
      end
    end
  end
`else
  always_comb begin
    boundary = (cnt == period_act);
    cnt_next = boundary ? '0 : cnt + ONE;
  end
`endif

  // Unsigned compare at full width: duty 0 -> never high, duty > P -> always.
  always_comb begin
    pwm_next = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      pwm_next[k] = (cnt < duty_act[k*CNT_W +: CNT_W]);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt          <= '0;
      period_act   <= '1;
      duty_act     <= '0;
      period_shd   <= '0;
      duty_shd     <= '0;
      pending      <= 1'b0;
      cfg_ready_o  <= 1'b1;
      pwm_o        <= '0;
      period_end_o <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      dir          <= DIR_UP;
      mode_act     <= 1'b0;
      mode_shd     <= 1'b0;
`endif
    end else begin
      if (handshake) begin
        period_shd  <= period_i;
        duty_shd    <= duty_i;
`ifdef PWM_CENTER_ALIGN_EN
        mode_shd    <= mode_i;
`endif
        pending     <= 1'b1;
        cfg_ready_o <= 1'b0;
      end else if (commit) begin
        period_act  <= period_shd;
        duty_act    <= duty_shd;
`ifdef PWM_CENTER_ALIGN_EN
        mode_act    <= mode_shd;
`endif
        pending     <= 1'b0;
        cfg_ready_o <= 1'b1;
      end

      if (running) begin
        // A running commit only happens at a boundary, where cnt_next is
        // already 0 and the direction has returned to up.
        cnt          <= cnt_next;
        pwm_o        <= pwm_next;
        period_end_o <= boundary;
`ifdef PWM_CENTER_ALIGN_EN
        dir          <= dir_next;
`endif
      end else begin
        cnt          <= '0;
        pwm_o        <= '0;
        period_end_o <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        dir          <= DIR_UP;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
`timescale 1ns/1ps
// Testbench for pwm_multi_ch (default edge-mode build).
module tb_pwm_multi_ch;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CNT_W  = 12;

  logic                    clk;
  logic                    reset_ni;
  logic                    enable_ni;
  logic [CNT_W-1:0]        period;
  logic [NUM_CH*CNT_W-1:0] duty;
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [NUM_CH-1:0]       pwm;
  logic                    period_end;
`ifdef PWM_CENTER_ALIGN_EN
  logic                    mode;
`endif

  int errors = 0;
  int checks = 0;

  // One expected record per completed period: length and high count per channel.
  typedef struct {
    int len;
    int hi [NUM_CH];
  } rec_t;

  rec_t exp_q[$];
  logic run_seen;

  pwm_multi_ch #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .reset_ni     (reset_ni),
    .enable_ni    (enable_ni),
    .period_i     (period),
    .duty_i       (duty),
    .cfg_valid_i  (cfg_valid),
`ifdef PWM_CENTER_ALIGN_EN
    .mode_i       (mode),
`endif
    .cfg_ready_o  (cfg_ready),
    .pwm_o        (pwm),
    .period_end_o (period_end)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Outputs seen after a posedge belong to a running cycle only if the DUT
  // was running (and out of reset) at that edge.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) run_seen <= 1'b0;
    else           run_seen <= !enable_ni;
  end

  function automatic void push(input int len, input int h0, input int h1, input int h2);
    rec_t r;
    r.len   = len;
    r.hi[0] = h0;
    r.hi[1] = h1;
    r.hi[2] = h2;
    exp_q.push_back(r);
  endfunction

  // Monitor: accumulate each period and compare when period_end marks its end.
  initial begin : monitor
    int   len;
    int   hi [NUM_CH];
    rec_t e;
    bit   bad;
    len = 0;
    for (int k = 0; k < NUM_CH; k++) hi[k] = 0;
    forever begin
      @(negedge clk);
      if (run_seen !== 1'b1) begin
        len = 0;
        for (int k = 0; k < NUM_CH; k++) hi[k] = 0;
      end else begin
        len++;
        for (int k = 0; k < NUM_CH; k++) if (pwm[k] === 1'b1) hi[k]++;
        if (period_end === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL period_unexpected: got len=%0d hi=%0d/%0d/%0d required no period",
                     len, hi[0], hi[1], hi[2]);
          end else begin
            e   = exp_q.pop_front();
            bad = (len != e.len);
            for (int k = 0; k < NUM_CH; k++) if (hi[k] != e.hi[k]) bad = 1'b1;
            if (bad) begin
              errors++;
              $display("FAIL period_rec: got len=%0d hi=%0d/%0d/%0d required len=%0d hi=%0d/%0d/%0d",
                       len, hi[0], hi[1], hi[2], e.len, e.hi[0], e.hi[1], e.hi[2]);
            end
          end
          len = 0;
          for (int k = 0; k < NUM_CH; k++) hi[k] = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic wait_pe(input int bound);
    bit got;
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(posedge clk);
      #1;
      if (period_end === 1'b1) got = 1'b1;
    end
    chk("period_end_wait", {31'b0, got}, 32'd1);
  endtask

  task automatic offer(input int p, input int d0, input int d1, input int d2, input bit drop);
    bit hs;
    hs        = 1'b0;
    period    = CNT_W'(p);
    duty      = {CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
    cfg_valid = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin
      hs = (cfg_ready === 1'b1);
      @(posedge clk);
      #1;
    end
    chk("handshake_wait", {31'b0, hs}, 32'd1);
    chk("ready_drop", {31'b0, cfg_ready}, 32'd0);
    if (drop) cfg_valid = 1'b0;
  endtask

  initial begin : stim
    reset_ni  = 1'b0;
    enable_ni = 1'b0;
    cfg_valid = 1'b0;
    period    = '0;
    duty      = '0;
`ifdef PWM_CENTER_ALIGN_EN
    mode      = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pwm", {29'b0, pwm}, 32'd0);
    chk("reset_pe", {31'b0, period_end}, 32'd0);
    chk("reset_ready", {31'b0, cfg_ready}, 32'd1);
    reset_ni = 1'b1;

    // First set commits after the 4096-clock reset period
    push(4096, 0, 0, 0);
    offer(9, 0, 3, 12, 1'b1);
    push(10, 0, 3, 10);
    push(10, 0, 3, 10);
    push(10, 0, 3, 10);
    wait_pe(5000);
    chk("ready_after_commit", {31'b0, cfg_ready}, 32'd1);
    wait_pe(20);
    wait_pe(20);

    // Offer P=4 at cnt=5: old period finishes, then 5-clock periods
    repeat (5) @(posedge clk);
    #1;
    offer(4, 0, 2, 12, 1'b1);
    wait_pe(20);
    chk("ready_after_commit2", {31'b0, cfg_ready}, 32'd1);
    push(5, 0, 2, 5);
    push(5, 0, 2, 5);
    wait_pe(20);
    wait_pe(20);

    // Valid held high with alternating sets: one accepted per period
    push(5, 0, 2, 5);
    push(5, 1, 2, 3);
    push(8, 0, 8, 4);
    push(5, 1, 2, 3);
    push(8, 0, 8, 4);
    offer(4, 1, 2, 3, 1'b0);
    offer(7, 0, 8, 4, 1'b0);
    offer(4, 1, 2, 3, 1'b0);
    offer(7, 0, 8, 4, 1'b1);
    wait_pe(20);
    wait_pe(20);

    // Stopped: outputs low, handshake commits on the next clock
    enable_ni = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("stop_pwm", {29'b0, pwm}, 32'd0);
    chk("stop_pe", {31'b0, period_end}, 32'd0);
    offer(3, 2, 0, 5, 1'b1);
    @(posedge clk);
    #1;
    chk("stop_commit_ready", {31'b0, cfg_ready}, 32'd1);
    chk("stop_pwm2", {29'b0, pwm}, 32'd0);
    chk("stop_pe2", {31'b0, period_end}, 32'd0);
    push(4, 2, 0, 4);
    push(4, 2, 0, 4);
    push(4, 2, 0, 4);
    enable_ni = 1'b0;
    wait_pe(20);
    wait_pe(20);
    wait_pe(20);

    // Asynchronous reset mid-period with a set pending
    offer(9, 5, 5, 5, 1'b1);
    #2;
    reset_ni = 1'b0;
    #1;
    chk("async_pwm", {29'b0, pwm}, 32'd0);
    chk("async_ready", {31'b0, cfg_ready}, 32'd1);
    chk("async_pe", {31'b0, period_end}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_ni = 1'b1;
    push(4096, 0, 0, 0);
    push(4096, 0, 0, 0);
    wait_pe(5000);
    chk("ready_after_reset", {31'b0, cfg_ready}, 32'd1);
    wait_pe(5000);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
